// File: rtl/reversible_alu_pipe_if.sv
// rtl/reversible_alu_pipe_if.sv - operand/result handshake bundle for reversible_alu_pipe
interface reversible_alu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             cin;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] P;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             carry;
   logic             zero;
   logic             op_err;

   modport master (
      output in_valid, op, cin, A, B, C, out_ready,
      input  in_ready, out_valid, P, Q, R, carry, zero, op_err
   );

   modport slave (
      input  in_valid, op, cin, A, B, C, out_ready,
      output in_ready, out_valid, P, Q, R, carry, zero, op_err
   );
endinterface

// File: rtl/reversible_alu_pipe.sv
// rtl/reversible_alu_pipe.sv - two-stage elastic pipeline of reversible gates (Fredkin/Feynman/Peres/add/sub)
module reversible_alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reversible_alu_pipe_if.slave io
);
   localparam logic [2:0] OP_FREDKIN = 3'd0;
   localparam logic [2:0] OP_FEYNMAN = 3'd1;
   localparam logic [2:0] OP_PERES   = 3'd2;
   localparam logic [2:0] OP_ADD     = 3'd3;
   localparam logic [2:0] OP_SUB     = 3'd4;

   logic             r_rst_done;
   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic             r_s1_cin;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [WIDTH-1:0] r_s1_c;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_p;
   logic [WIDTH-1:0] r_s2_q;
   logic [WIDTH-1:0] r_s2_r;
   logic             r_s2_carry;
   logic             r_s2_zero;
   logic             r_s2_err;

   logic             w_s2_load;
   logic             w_s1_load;
   logic             w_in_fire;
   logic [WIDTH-1:0] w_addb;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_r;
   logic             w_carry;
   logic             w_err;

   assign w_s2_load   = !r_s2_valid || io.out_ready;
   assign w_s1_load   = !r_s1_valid || w_s2_load;
   assign io.in_ready = r_rst_done && w_s1_load;
   assign w_in_fire   = io.in_valid && io.in_ready;

   // Holds in_ready low until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_done <= 1'b0;
      else        r_rst_done <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= 3'd0;
         r_s1_cin   <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_c     <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_s1_op  <= io.op;
            r_s1_cin <= io.cin;
            r_s1_a   <= io.A;
            r_s1_b   <= io.B;
            r_s1_c   <= io.C;
         end
      end
   end

   // Ripple of Peres full adders: each bit is two chained Peres cells.
   always_comb begin : peres_adder
      logic c;
      w_addb = (r_s1_op == OP_SUB) ? ~r_s1_b : r_s1_b;
      c      = (r_s1_op == OP_SUB) ? 1'b1 : r_s1_cin;
      w_sum  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_sum[i] = r_s1_a[i] ^ w_addb[i] ^ c;
         c        = ((r_s1_a[i] ^ w_addb[i]) & c) ^ (r_s1_a[i] & w_addb[i]);
      end
      w_cout = c;
   end

   always_comb begin
      w_p     = r_s1_a;
      w_q     = r_s1_b;
      w_r     = r_s1_c;
      w_carry = 1'b0;
      w_err   = 1'b0;
      case (r_s1_op)
         OP_FREDKIN: begin
            w_p = r_s1_c;
            w_q = (~r_s1_c & r_s1_a) | (r_s1_c & r_s1_b);
            w_r = (~r_s1_c & r_s1_b) | (r_s1_c & r_s1_a);
         end
         OP_FEYNMAN: begin
            w_q = r_s1_a ^ r_s1_b;
         end
         OP_PERES: begin
            w_q = r_s1_a ^ r_s1_b;
            w_r = (r_s1_a & r_s1_b) ^ r_s1_c;
         end
         OP_ADD, OP_SUB: begin
            w_q     = w_sum;
            w_r     = '0;
            w_carry = w_cout;
         end
         default: begin
            w_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_p     <= '0;
         r_s2_q     <= '0;
         r_s2_r     <= '0;
         r_s2_carry <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_p     <= w_p;
            r_s2_q     <= w_q;
            r_s2_r     <= w_r;
            r_s2_carry <= w_carry;
            r_s2_zero  <= (w_q == '0);
            r_s2_err   <= w_err;
         end
      end
   end

   assign io.out_valid = r_s2_valid;
   assign io.P         = r_s2_p;
   assign io.Q         = r_s2_q;
   assign io.R         = r_s2_r;
   assign io.carry     = r_s2_carry;
   assign io.zero      = r_s2_zero;
   assign io.op_err    = r_s2_err;
endmodule

// File: tb/tb_reversible_alu_pipe.sv
// tb/tb_reversible_alu_pipe.sv - randomized scoreboard bench for reversible_alu_pipe at WIDTH 32 and 8
module tb_reversible_alu_pipe;
   logic clk;
   logic rst_n;

   reversible_alu_pipe_if #(.WIDTH(32)) if32 ();
   reversible_alu_pipe_if #(.WIDTH(8))  if8 ();

   reversible_alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .io(if32.slave));
   reversible_alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .io(if8.slave));

   typedef struct {
      logic [63:0] p;
      logic [63:0] q;
      logic [63:0] r;
      logic        cy;
      logic        zr;
      logic        er;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   int   n_block = 0;
   int   cyc     = 0;
   int   stall_base = 0;
   int   ready_mode = 0;
   exp_t sb[$];
   exp_t mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: swap-by-control, XOR gates, plain integer add/subtract.
   function automatic exp_t ref_model(input int w, input logic [2:0] op, input logic cin,
                                      input logic [63:0] a_in, input logic [63:0] b_in,
                                      input logic [63:0] c_in);
      exp_t        e;
      logic [63:0] m, a, b, c;
      logic [64:0] s;
      m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = a_in & m;
      b = b_in & m;
      c = c_in & m;
      e.p = a; e.q = b; e.r = c; e.cy = 1'b0; e.er = 1'b0;
      case (op)
         3'd0: begin
            e.p = c;
            for (int i = 0; i < w; i++) begin
               if (c[i]) begin e.q[i] = b[i]; e.r[i] = a[i]; end
               else      begin e.q[i] = a[i]; e.r[i] = b[i]; end
            end
         end
         3'd1: e.q = a ^ b;
         3'd2: begin e.q = a ^ b; e.r = (a & b) ^ c; end
         3'd3: begin
            s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            e.q = s[63:0] & m; e.cy = s[w]; e.r = 64'd0;
         end
         3'd4: begin
            e.q = (a - b) & m; e.cy = (a >= b); e.r = 64'd0;
         end
         default: e.er = 1'b1;
      endcase
      e.zr = (e.q == 64'd0);
      return e;
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      if32.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            0:       if32.out_ready = 1'b1;
            1:       if32.out_ready = ($urandom_range(0, 3) != 0);
            default: if32.out_ready = !((cyc - stall_base) >= 3 && (cyc - stall_base) <= 6);
         endcase
      end
   end

   // Scoreboard for the 32-bit instance; also checks held outputs while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (if32.in_valid && !if32.in_ready) n_block++;
         if (if32.out_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_out", 64'(if32.out_valid), 64'd0);
            end else begin
               mon_e = sb[0];
               check_eq("sb_p",     64'(if32.P),      mon_e.p);
               check_eq("sb_q",     64'(if32.Q),      mon_e.q);
               check_eq("sb_r",     64'(if32.R),      mon_e.r);
               check_eq("sb_carry", 64'(if32.carry),  64'(mon_e.cy));
               check_eq("sb_zero",  64'(if32.zero),   64'(mon_e.zr));
               check_eq("sb_err",   64'(if32.op_err), 64'(mon_e.er));
               if (if32.out_ready) begin
                  sb.delete(0);
                  n_out++;
               end
            end
         end
         if (if32.in_valid && if32.in_ready)
            sb.push_back(ref_model(32, if32.op, if32.cin, 64'(if32.A), 64'(if32.B), 64'(if32.C)));
      end
   end

   task automatic send32(input logic [2:0] op, input logic cin,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      int k;
      if32.op = op; if32.cin = cin; if32.A = a; if32.B = b; if32.C = c;
      if32.in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!if32.in_ready && k < 50);
      check_eq("accept32", 64'(if32.in_ready), 64'd1);
      @(posedge clk);
      #1;
      if32.in_valid = 1'b0;
   endtask

   task automatic dir32(input string tag, input logic [2:0] op, input logic cin,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] ep, input logic [31:0] eq, input logic [31:0] er,
                        input logic ecy, input logic ezr, input logic eerr);
      send32(op, cin, a, b, c);
      check_eq({tag, "_early"}, 64'(if32.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid"}, 64'(if32.out_valid), 64'd1);
      check_eq({tag, "_p"},     64'(if32.P),      64'(ep));
      check_eq({tag, "_q"},     64'(if32.Q),      64'(eq));
      check_eq({tag, "_r"},     64'(if32.R),      64'(er));
      check_eq({tag, "_carry"}, 64'(if32.carry),  64'(ecy));
      check_eq({tag, "_zero"},  64'(if32.zero),   64'(ezr));
      check_eq({tag, "_err"},   64'(if32.op_err), 64'(eerr));
   endtask

   task automatic run8(input logic [2:0] op, input logic cin,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_t e;
      int   k;
      e = ref_model(8, op, cin, 64'(a), 64'(b), 64'(c));
      if8.op = op; if8.cin = cin; if8.A = a; if8.B = b; if8.C = c;
      if8.in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!if8.in_ready && k < 20);
      check_eq("w8_accept", 64'(if8.in_ready), 64'd1);
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
      check_eq("w8_early", 64'(if8.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check_eq("w8_valid", 64'(if8.out_valid), 64'd1);
      check_eq("w8_p",     64'(if8.P),      e.p);
      check_eq("w8_q",     64'(if8.Q),      e.q);
      check_eq("w8_r",     64'(if8.R),      e.r);
      check_eq("w8_carry", 64'(if8.carry),  64'(e.cy));
      check_eq("w8_zero",  64'(if8.zero),   64'(e.zr));
      check_eq("w8_err",   64'(if8.op_err), 64'(e.er));
   endtask

   initial begin
      int out0;
      int blk0;
      rst_n = 1'b0;
      if32.in_valid = 1'b0; if32.op = 3'd0; if32.cin = 1'b0;
      if32.A = '0; if32.B = '0; if32.C = '0;
      if8.in_valid = 1'b0; if8.op = 3'd0; if8.cin = 1'b0;
      if8.A = '0; if8.B = '0; if8.C = '0; if8.out_ready = 1'b1;

      #12;
      check_eq("rst_out_valid", 64'(if32.out_valid), 64'd0);
      check_eq("rst_in_ready",  64'(if32.in_ready),  64'd0);
      check_eq("rst_pqr",       64'(if32.P | if32.Q | if32.R), 64'd0);
      check_eq("rst_flags",     64'({if32.carry, if32.zero, if32.op_err}), 64'd0);

      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_eq("rel_in_ready_pre", 64'(if32.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check_eq("rel_in_ready_post", 64'(if32.in_ready), 64'd1);

      dir32("fredkin", 3'd0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000,
            32'hFFFF0000, 32'h5A5AA5A5, 32'hA5A55A5A, 1'b0, 1'b0, 1'b0);
      dir32("peres", 3'd2, 1'b0, 32'h12345678, 32'h87654321, 32'h00000000,
            32'h12345678, 32'h95511559, 32'h02244220, 1'b0, 1'b0, 1'b0);
      dir32("add_wrap", 3'd3, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h0,
            32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0);
      dir32("sub_borrow", 3'd4, 1'b0, 32'h0, 32'h1, 32'h0,
            32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
      dir32("reserved", 3'd6, 1'b1, 32'h1, 32'h2, 32'h3,
            32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1);

      // Back-to-back stream with out_ready low for relative cycles 3..6.
      @(posedge clk);
      #2;
      stall_base = cyc;
      ready_mode = 2;
      out0 = n_out;
      blk0 = n_block;
      for (int i = 0; i < 5; i++)
         send32(3'(i), 1'(i & 1), 32'h1000_0000 * 32'(i + 1) + 32'h0F0F, 32'h0100_0203 * 32'(i + 3), 32'hFF00_FF00 ^ 32'(i));
      repeat (12) @(posedge clk);
      ready_mode = 0;
      @(negedge clk);
      check_eq("stall_in_ready_dropped", 64'(n_block > blk0), 64'd1);
      check_eq("stall_out_count",        64'(n_out - out0),   64'd5);
      check_eq("stall_drained",          64'(sb.size()),      64'd0);

      // Reset with two sets in flight.
      @(posedge clk);
      #1;
      send32(3'd1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0F0F_0F0F);
      send32(3'd3, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 64'(if32.out_valid), 64'd0);
      check_eq("mid_rst_pqr",       64'(if32.P | if32.Q | if32.R), 64'd0);
      check_eq("mid_rst_in_ready",  64'(if32.in_ready), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_eq("mid_rel_in_ready_pre", 64'(if32.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check_eq("mid_rel_in_ready_post", 64'(if32.in_ready), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check_eq("no_stale_out", 64'(if32.out_valid), 64'd0);
      dir32("post_rst_feynman", 3'd1, 1'b0, 32'hF0F0_0000, 32'h3C3C_FFFF, 32'hAAAA_5555,
            32'hF0F0_0000, 32'hCCCC_FFFF, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0);

      // WIDTH=8 instance: directed Feynman, arithmetic edges, then random.
      run8(3'd1, 1'b0, 8'hF0, 8'h3C, 8'hAA);
      check_eq("w8_feynman_q", 64'(if8.Q), 64'hCC);
      check_eq("w8_feynman_r", 64'(if8.R), 64'hAA);
      run8(3'd3, 1'b1, 8'hFF, 8'h00, 8'h00);
      run8(3'd4, 1'b0, 8'h05, 8'h05, 8'h00);
      run8(3'd4, 1'b0, 8'h00, 8'hFF, 8'h00);
      for (int i = 0; i < 30; i++)
         run8(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), 8'($urandom));

      // Random stream on the 32-bit instance with random backpressure.
      ready_mode = 1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send32(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rnd32(), rnd32(), rnd32());
      end
      ready_mode = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("random_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
